// File: rtl/memwb.sv
// Memory/write-back stage: load/store over a req/ack bus, load formatting, rd write and next PC.
// Latency: 2 cycles to done_o without a bus access, 2 + N with one (N = cycles until ack, capped by TIMEOUT).
// Backpressure: mem_req_o is held until mem_ack_i; done_o is held until stage_i leaves MEM_STAGE.
module memwb #(
  parameter int MEM_STAGE = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic [4:0]  itype_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] y_i,
  input  logic [31:0] pass_i,
  input  logic [31:0] pc_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] pc_next_o,
  output logic        done_o,
  output logic [1:0]  fault_o
);

  localparam logic [4:0] RTYPE  = 5'd0;
  localparam logic [4:0] ITYPE  = 5'd1;
  localparam logic [4:0] STYPE  = 5'd2;
  localparam logic [4:0] BTYPE  = 5'd3;
  localparam logic [4:0] UTYPE  = 5'd4;
  localparam logic [4:0] LTYPE  = 5'd5;
  localparam logic [4:0] JRTYPE = 5'd6;

  localparam logic [2:0] STAGE   = 3'(MEM_STAGE);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, WB, DONE} state_t;

  state_t      state;
  logic [4:0]  itype_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] y_q;
  logic [31:0] pc_q;
  logic [7:0]  wait_cnt;

  // Only funct3 and rd are needed from the instruction word.
  logic unused_ir;
  assign unused_ir = &{1'b0, ir_i[31:15], ir_i[6:0]};

  logic [2:0] funct3_in;
  logic [4:0] rd_in;
  logic       is_mem_in;
  assign funct3_in = ir_i[14:12];
  assign rd_in     = ir_i[11:7];
  assign is_mem_in = (itype_i == LTYPE) || (itype_i == STYPE);

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
    else if (f3[1:0] == 2'b01 && lo[0])               bad = 1'b1;
    else if (f3[1:0] == 2'b10 && lo != 2'b00)         bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b100:  v = {24'd0, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b101:  v = {16'd0, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic wb_we(input logic [4:0] it, input logic [4:0] rd, input logic load_ok);
    logic we;
    case (it)
      RTYPE, ITYPE, UTYPE, JRTYPE: we = 1'b1;
      LTYPE:                       we = load_ok;
      default:                     we = 1'b0;
    endcase
    return we && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] wb_data(input logic [4:0] it, input logic [31:0] y,
                                          input logic [31:0] pc, input logic [31:0] ldata);
    logic [31:0] d;
    case (it)
      RTYPE, ITYPE, UTYPE: d = y;
      LTYPE:               d = ldata;
      JRTYPE:              d = pc + 32'd4;
      default:             d = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] wb_pc(input logic [4:0] it, input logic [31:0] y,
                                        input logic [31:0] pc);
    logic [31:0] p;
    case (it)
      BTYPE:   p = y;
      JRTYPE:  p = y & ~32'd1;
      default: p = pc + 32'd4;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      itype_q     <= 5'd0;
      funct3_q    <= 3'd0;
      rd_q        <= 5'd0;
      y_q         <= 32'd0;
      pc_q        <= 32'd0;
      wait_cnt    <= 8'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_be_o    <= 4'd0;
      rd_we_o     <= 1'b0;
      rd_addr_o   <= 5'd0;
      rd_data_o   <= 32'd0;
      pc_next_o   <= 32'd0;
      done_o      <= 1'b0;
      fault_o     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (stage_i == STAGE) begin
            itype_q   <= itype_i;
            funct3_q  <= funct3_in;
            rd_q      <= rd_in;
            y_q       <= y_i;
            pc_q      <= pc_i;
            rd_addr_o <= rd_in;
            wait_cnt  <= 8'd0;
            if (is_mem_in && !misaligned(funct3_in, y_i[1:0])) begin
              state       <= ACCESS;
              mem_req_o   <= 1'b1;
              mem_we_o    <= (itype_i == STYPE);
              mem_addr_o  <= {y_i[31:2], 2'b00};
              mem_be_o    <= access_be(funct3_in, y_i[1:0]);
              mem_wdata_o <= store_data(funct3_in, pass_i);
            end else begin
              // Non-memory classes and misaligned accesses both skip the bus.
              state     <= WB;
              rd_we_o   <= wb_we(itype_i, rd_in, 1'b0);
              rd_data_o <= wb_data(itype_i, y_i, pc_i, 32'd0);
              pc_next_o <= wb_pc(itype_i, y_i, pc_i);
              if (is_mem_in) fault_o <= FAULT_MISALIGN;
            end
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            state     <= WB;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            rd_we_o   <= wb_we(itype_q, rd_q, 1'b1);
            rd_data_o <= wb_data(itype_q, y_q, pc_q, load_fmt(funct3_q, y_q[1:0], mem_rdata_i));
            pc_next_o <= wb_pc(itype_q, y_q, pc_q);
          end else if (wait_cnt == TO_LAST) begin
            state     <= WB;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            rd_we_o   <= 1'b0;
            rd_data_o <= 32'd0;
            pc_next_o <= wb_pc(itype_q, y_q, pc_q);
            fault_o   <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state   <= DONE;
          rd_we_o <= 1'b0;
          done_o  <= 1'b1;
        end
        DONE: begin
          // Stay parked until the sequencer moves on, so a held stage cannot re-trigger.
          if (stage_i != STAGE) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memwb.sv
// Directed bench for memwb: drives one instruction per transaction and checks bus, write-back and PC.
module tb_memwb;

  localparam logic [4:0] RTYPE  = 5'd0;
  localparam logic [4:0] ITYPE  = 5'd1;
  localparam logic [4:0] STYPE  = 5'd2;
  localparam logic [4:0] BTYPE  = 5'd3;
  localparam logic [4:0] UTYPE  = 5'd4;
  localparam logic [4:0] LTYPE  = 5'd5;
  localparam logic [4:0] JRTYPE = 5'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  stage_i;
  logic [4:0]  itype_i;
  logic [31:0] ir_i, y_i, pass_i, pc_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, pc_next_o;
  logic        done_o;
  logic [1:0]  fault_o;

  memwb #(.MEM_STAGE(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .stage_i(stage_i), .itype_i(itype_i), .ir_i(ir_i),
    .y_i(y_i), .pass_i(pass_i), .pc_i(pc_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .pc_next_o(pc_next_o), .done_o(done_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Observations from the last transaction.
  int          r_req, r_we, r_done_k, r_unstable;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data, r_pc, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_mwe;
  logic [1:0]  r_fault;

  task automatic run_txn(input logic [4:0] it, input logic [31:0] ir, input logic [31:0] y,
                         input logic [31:0] pass, input logic [31:0] pc, input bit ack_en,
                         input int wait_n, input logic [31:0] rdata);
    bit seen_done;
    @(negedge clk);
    itype_i = it; ir_i = ir; y_i = y; pass_i = pass; pc_i = pc;
    mem_rdata_i = rdata; mem_ack_i = 1'b0; stage_i = 3'd4;
    r_req = 0; r_we = 0; r_done_k = 0; r_unstable = 0;
    r_rd_addr = 5'd0; r_rd_data = 32'd0; r_pc = 32'd0; r_fault = 2'd0;
    r_addr = 32'd0; r_wdata = 32'd0; r_be = 4'd0; r_mwe = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 60 && !seen_done; k++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (r_req == 0) begin
          r_addr = mem_addr_o; r_wdata = mem_wdata_o; r_be = mem_be_o; r_mwe = mem_we_o;
        end else if (mem_addr_o !== r_addr || mem_wdata_o !== r_wdata ||
                     mem_be_o !== r_be || mem_we_o !== r_mwe) begin
          r_unstable++;
        end
        r_req++;
      end
      mem_ack_i = ack_en && mem_req_o && (r_req == wait_n + 1);
      if (rd_we_o) begin
        r_we++; r_rd_addr = rd_addr_o; r_rd_data = rd_data_o;
      end
      if (done_o) begin
        seen_done = 1'b1; r_done_k = k; r_pc = pc_next_o; r_fault = fault_o;
      end
    end
    if (!seen_done) chk("done_seen", 32'd0, 32'd1);
    mem_ack_i = 1'b0;
    stage_i = 3'd0;
    @(negedge clk);
    chk("done_fall", {31'd0, done_o}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int nw, nr, nd, first_done;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stage_i = 3'd0; itype_i = 5'd0; ir_i = 32'd0; y_i = 32'd0;
    pass_i = 32'd0; pc_i = 32'd0; mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
    #12;
    chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst_done",  {31'd0, done_o},    32'd0);
    chk("rst_fault", {30'd0, fault_o},   32'd0);
    chk("rst_rdwe",  {31'd0, rd_we_o},   32'd0);
    chk("rst_pc",    pc_next_o,          32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADDI x5: no bus, write 0x2A, done two cycles after stage entry
    run_txn(ITYPE, 32'h0000_0293, 32'h0000_002A, 32'd0, 32'h100, 1'b0, 0, 32'd0);
    chk("addi_we",    r_we,           1);
    chk("addi_rd",    {27'd0, r_rd_addr}, 32'd5);
    chk("addi_data",  r_rd_data,      32'h2A);
    chk("addi_pc",    r_pc,           32'h104);
    chk("addi_donek", r_done_k,       2);
    chk("addi_req",   r_req,          0);

    // LB from lane 3 after three wait cycles
    run_txn(LTYPE, 32'h0000_0303, 32'h1003, 32'd0, 32'h200, 1'b1, 3, 32'h8012_3456);
    chk("lb_addr",   r_addr,          32'h1000);
    chk("lb_req",    r_req,           4);
    chk("lb_mwe",    {31'd0, r_mwe},  32'd0);
    chk("lb_data",   r_rd_data,       32'hFFFF_FF80);
    chk("lb_we",     r_we,            1);
    chk("lb_donek",  r_done_k,        6);
    chk("lb_stable", r_unstable,      0);

    run_txn(LTYPE, 32'h0000_4303, 32'h1003, 32'd0, 32'h204, 1'b1, 3, 32'h8012_3456);
    chk("lbu_data",  r_rd_data,       32'h0000_0080);

    // LH from the upper half with ack in the first ACCESS cycle
    run_txn(LTYPE, 32'h0000_1203, 32'h1002, 32'd0, 32'h208, 1'b1, 0, 32'h8012_3456);
    chk("lh_req",    r_req,           1);
    chk("lh_data",   r_rd_data,       32'hFFFF_8012);
    chk("lh_rd",     {27'd0, r_rd_addr}, 32'd4);
    chk("lh_donek",  r_done_k,        3);

    // SH upper half
    run_txn(STYPE, 32'h0000_1123, 32'h2002, 32'h1234_ABCD, 32'h200, 1'b1, 1, 32'd0);
    chk("sh_mwe",    {31'd0, r_mwe},  32'd1);
    chk("sh_be",     {28'd0, r_be},   32'hC);
    chk("sh_wdata",  r_wdata,         32'hABCD_ABCD);
    chk("sh_addr",   r_addr,          32'h2000);
    chk("sh_we",     r_we,            0);
    chk("sh_pc",     r_pc,            32'h204);

    // SB lane 1
    run_txn(STYPE, 32'h0000_0023, 32'h3001, 32'h0000_00A5, 32'h300, 1'b1, 0, 32'd0);
    chk("sb_be",     {28'd0, r_be},   32'h2);
    chk("sb_wdata",  r_wdata,         32'hA5A5_A5A5);

    run_txn(BTYPE, 32'h0000_0463, 32'h400, 32'd0, 32'h3C0, 1'b0, 0, 32'd0);
    chk("br_pc",     r_pc,            32'h400);
    chk("br_we",     r_we,            0);

    run_txn(JRTYPE, 32'h0000_00E7, 32'h301, 32'd0, 32'h80, 1'b0, 0, 32'd0);
    chk("jr_pc",     r_pc,            32'h300);
    chk("jr_data",   r_rd_data,       32'h84);
    chk("jr_we",     r_we,            1);
    chk("jr_fault",  {30'd0, r_fault}, 32'd0);

    // Misaligned LW
    run_txn(LTYPE, 32'h0000_2183, 32'h2001, 32'd0, 32'h600, 1'b1, 0, 32'hDEAD_BEEF);
    chk("mis_req",   r_req,           0);
    chk("mis_fault", {30'd0, r_fault}, 32'd1);
    chk("mis_we",    r_we,            0);
    chk("mis_donek", r_done_k,        2);
    chk("mis_pc",    r_pc,            32'h604);
    chk("mis_sticky", {30'd0, fault_o}, 32'd1);

    // LW with no ack
    pulse_reset();
    run_txn(LTYPE, 32'h0000_2183, 32'h2004, 32'd0, 32'h700, 1'b0, 0, 32'd0);
    chk("to_req",    r_req,           16);
    chk("to_fault",  {30'd0, r_fault}, 32'd2);
    chk("to_we",     r_we,            0);
    chk("to_donek",  r_done_k,        18);

    // Reset mid-ACCESS, then one ADDI x0 with stage held at 4
    @(negedge clk);
    itype_i = LTYPE; ir_i = 32'h0000_2183; y_i = 32'h3000; pc_i = 32'h800; stage_i = 3'd4;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("mid_rst_done",  {31'd0, done_o},    32'd0);
    chk("mid_rst_fault", {30'd0, fault_o},   32'd0);
    itype_i = ITYPE; ir_i = 32'h0000_0013; y_i = 32'h7; pc_i = 32'h500;
    @(negedge clk);
    reset = 1'b1;
    nw = 0; nr = 0; nd = 0; first_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rd_we_o) nw++;
      if (mem_req_o) nr++;
      if (done_o) begin
        nd++;
        if (first_done == 0) first_done = k;
      end
    end
    chk("x0_we",     nw,         0);
    chk("x0_req",    nr,         0);
    chk("x0_donek",  first_done, 2);
    chk("x0_held",   nd,         7);
    chk("x0_pc",     pc_next_o,  32'h504);
    stage_i = 3'd0;
    @(negedge clk);
    chk("x0_fall",   {31'd0, done_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
